if_fetch_stage: RTL and testbench

- Instruction fetch stage. Sits directly upstream of the decode/control unit and supplies the 32-bit instruction whose opcode, funct3 and funct7 fields drive decode.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO so decode stalls never drop a fetch.
- Squashes in-flight fetches on a branch/jump redirect from execute.

---
 rtl/if_fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers returned words in a small FIFO for decode and squashes in-flight
// fetches on a redirect from execute.
// Optional build macro IF_ALIGN_CHECK_EN: a redirect to a misaligned target
// parks the stage in a fault state and presents one marked NOP to decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        inst_fault_o
);

    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    // Wide enough for fifo count plus outstanding (up to 2*FIFO_DEPTH)
    localparam int unsigned CW  = PW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d, target_pc;
    logic [CW-1:0] outstanding_q, outstanding_d, kill_q, kill_d, count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_inst_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic          accept, pop, push, fetch_block, fault_push;
    logic [31:0]   push_inst;

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StRun, StFaultWait, StFaultHold} state_e;
    state_e state_q, state_d;
    logic   fifo_fault_q [FIFO_DEPTH];

    assign target_pc = redirect_pc_i;

    // Fault state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StRun;
        else       state_q <= state_d;
    end

    // Fault FSM: wait for stale responses to drain, then emit one marked NOP
    always_comb begin
        state_d     = state_q;
        fault_push  = 1'b0;
        fetch_block = (state_q != StRun);
        if (redirect_i) begin
            state_d = (redirect_pc_i[1:0] != 2'b00) ? StFaultWait : StRun;
        end else begin
            case (state_q)
                StFaultWait: begin
                    if (kill_q == '0) begin
                        fault_push = 1'b1;
                        state_d    = StFaultHold;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fault marker storage alongside the instruction FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_fault_q[i] <= 1'b0;
        end else if (push) begin
            fifo_fault_q[wr_ptr_q] <= fault_push & ~imem_rvalid_i;
        end
    end

    assign inst_fault_o = fifo_fault_q[rd_ptr_q] & (count_q != '0);
`else
    // Low address bits are simply dropped
    assign target_pc    = redirect_pc_i & 32'hFFFF_FFFC;
    assign fetch_block  = 1'b0;
    assign fault_push   = 1'b0;
    assign inst_fault_o = 1'b0;
`endif

    // Credit rule: never have more words in flight or buffered than FIFO slots
    assign imem_req_o   = ~rst_i & ~redirect_i & ~fetch_block &
                          ((count_q + outstanding_q) < CW'(FIFO_DEPTH));
    assign imem_addr_o  = pc_q;
    assign accept       = imem_req_o & imem_gnt_i;
    assign inst_valid_o = (count_q != '0) & ~redirect_i;
    assign pop          = inst_valid_o & inst_ready_i;
    assign inst_o       = fifo_inst_q[rd_ptr_q];
    assign inst_pc_o    = fifo_pc_q[rd_ptr_q];

    // Next-state for PC, response tracking and FIFO pointers; redirect wins
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        push          = 1'b0;
        push_inst     = imem_rdata_i;
        if (redirect_i) begin
            pc_d          = target_pc;
            rsp_pc_d      = target_pc;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            // Every fetch still in flight belongs to the old path
            outstanding_d = outstanding_q - CW'(imem_rvalid_i);
            kill_d        = outstanding_q - CW'(imem_rvalid_i);
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (imem_rvalid_i) begin
                if (kill_q != '0) begin
                    kill_d = kill_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end else if (fault_push) begin
                push      = 1'b1;
                push_inst = NOP;
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid_i);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Instruction FIFO storage; cleared so an empty head reads as zero after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (push) begin
            fifo_inst_q[wr_ptr_q] <= push_inst;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with an in-order memory model and a
// scoreboard of granted fetches awaiting delivery to decode.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o, inst_ready_i, inst_fault_o;
    logic [31:0] inst_o, inst_pc_o;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i),
        .inst_fault_o (inst_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] gnt_log[$];
    int          gnt_cyc[$];
    int          total = 0, bad = 0, cyc = 0, gnt_cnt = 0;
    int          first_valid_cyc = -1, max_inflight = 0, n0 = 0;
    logic        gnt_en, rsp_en, ready_en, redir_now, samp_req, fault_seen;
    logic [31:0] redir_pc_now, exp_next_pc, samp_addr, held;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One clock: drive inputs after negedge, settle, then score the handshakes
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        imem_rvalid_i = rsp_en && (pend_q.size() > 0);
        imem_rdata_i  = imem_rvalid_i ? mem_data(pend_q[0]) : 32'h0;
        imem_gnt_i    = gnt_en;
        redirect_i    = redir_now;
        redirect_pc_i = redir_pc_now;
        inst_ready_i  = ready_en;
        #1;
        check_eq("addr", imem_addr_o, exp_next_pc);
        samp_req  = imem_req_o;
        samp_addr = imem_addr_o;
        if (imem_rvalid_i) void'(pend_q.pop_front());
        if (redirect_i) begin
            check_eq("redir_req", 32'(imem_req_o), 32'd0);
            check_eq("redir_valid", 32'(inst_valid_o), 32'd0);
            exp_q.delete();
`ifdef IF_ALIGN_CHECK_EN
            exp_next_pc = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                e = '{inst: NOP, pc: redirect_pc_i, fault: 1'b1};
                exp_q.push_back(e);
            end
`else
            exp_next_pc = {redirect_pc_i[31:2], 2'b00};
`endif
            redir_now = 1'b0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                pend_q.push_back(imem_addr_o);
                e = '{inst: mem_data(imem_addr_o), pc: imem_addr_o, fault: 1'b0};
                exp_q.push_back(e);
                gnt_log.push_back(imem_addr_o);
                gnt_cyc.push_back(cyc);
                gnt_cnt++;
                exp_next_pc = imem_addr_o + 32'd4;
            end
            if (inst_valid_o && inst_ready_i) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (inst_fault_o) fault_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("inst", inst_o, e.inst);
                    check_eq("inst_pc", inst_pc_o, e.pc);
                    check_eq("fault", 32'(inst_fault_o), 32'(e.fault));
                end
            end
            if (exp_q.size() > max_inflight) max_inflight = exp_q.size();
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_pc_i = 0; inst_ready_i = 0;
        gnt_en = 0; rsp_en = 1; ready_en = 1; redir_now = 0; redir_pc_now = 0;
        exp_next_pc = 32'h0; fault_seen = 0; samp_req = 0; samp_addr = 0; held = 0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_addr", imem_addr_o, 32'h0);
        check_eq("rst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_pc", inst_pc_o, 32'h0);
        check_eq("rst_fault", 32'(inst_fault_o), 32'd0);
        rst = 1'b0;

        // Streaming fetch with immediate grants and 1-cycle responses
        gnt_en = 1;
        repeat (6) cycle();
        check_eq("first_addr0", gnt_log[0], 32'h0);
        check_eq("first_addr1", gnt_log[1], 32'h4);
        check_eq("first_addr2", gnt_log[2], 32'h8);
        check_eq("gnt_gap1", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd1);
        check_eq("gnt_gap2", 32'(gnt_cyc[2] - gnt_cyc[0]), 32'd3);
        check_eq("first_latency", 32'(first_valid_cyc - gnt_cyc[0]), 32'd2);

        // Decode stall: credits cap in-flight plus buffered at FIFO depth
        ready_en = 0; max_inflight = 0;
        repeat (8) cycle();
        check_eq("stall_max", 32'(max_inflight <= 2), 32'd1);
        check_eq("stall_buf", 32'(exp_q.size()), 32'd2);
        check_eq("stall_req", 32'(samp_req), 32'd0);
        ready_en = 1;
        repeat (6) cycle();

        // Grant withheld: address holds
        gnt_en = 0;
        repeat (4) cycle();
        held = exp_next_pc;
        repeat (3) begin
            cycle();
            check_eq("hold_req", 32'(samp_req), 32'd1);
            check_eq("hold_addr", samp_addr, held);
        end

        // Redirect with two fetches outstanding
        rsp_en = 0; gnt_en = 1; n0 = gnt_cnt;
        repeat (3) cycle();
        check_eq("two_out", 32'(gnt_cnt - n0), 32'd2);
        redir_now = 1; redir_pc_now = 32'h100;
        cycle();
        rsp_en = 1; n0 = gnt_log.size();
        repeat (10) cycle();
        check_eq("redir_first_gnt", gnt_log[n0], 32'h100);

        // Redirect coinciding with the only outstanding response
        gnt_en = 0;
        repeat (5) cycle();
        check_eq("drained", 32'(exp_q.size() + pend_q.size()), 32'd0);
        gnt_en = 1;
        cycle();
        gnt_en = 0; redir_now = 1; redir_pc_now = 32'h180;
        cycle();
        gnt_en = 1; n0 = gnt_log.size();
        repeat (8) cycle();
        check_eq("coinc_first_gnt", gnt_log[n0], 32'h180);

        // PC wrap at the top of the address space
        redir_now = 1; redir_pc_now = 32'hFFFF_FFF8;
        cycle();
        n0 = gnt_log.size();
        repeat (10) cycle();
        check_eq("wrap0", gnt_log[n0], 32'hFFFF_FFF8);
        check_eq("wrap1", gnt_log[n0 + 1], 32'hFFFF_FFFC);
        check_eq("wrap2", gnt_log[n0 + 2], 32'h0);

        // Misaligned redirect target
        redir_now = 1; redir_pc_now = 32'h102;
        cycle();
        n0 = gnt_cnt; fault_seen = 0;
        repeat (8) cycle();
`ifdef IF_ALIGN_CHECK_EN
        check_eq("fault_no_req", 32'(gnt_cnt - n0), 32'd0);
        check_eq("fault_seen", 32'(fault_seen), 32'd1);
        check_eq("fault_one_entry", 32'(exp_q.size()), 32'd0);
        redir_now = 1; redir_pc_now = 32'h200;
        cycle();
        n0 = gnt_log.size();
        repeat (8) cycle();
        check_eq("fault_resume", gnt_log[n0], 32'h200);
`else
        check_eq("mask_gnt", gnt_log[gnt_log.size() - (gnt_cnt - n0)], 32'h100);
        check_eq("mask_nofault", 32'(fault_seen), 32'd0);
`endif

        // Final drain: everything granted reaches decode
        gnt_en = 0;
        repeat (6) cycle();
        check_eq("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
